// File: rtl/calc_operand_fsm_if.sv
// rtl/calc_operand_fsm_if.sv - switch/key/display bundle for the calculator front end
//
// Purpose: groups the operand entry inputs and display/status outputs of
// calc_operand_fsm into one interface.
// Ports (signals):
//   SW    [N-1:0]  operand switches, two's complement (master -> slave)
//   OP             function select, 0 = add, 1 = subtract (master -> slave)
//   KEY            raw active-low pushbutton (master -> slave)
//   DISP  [N-1:0]  signed value for the display stage (slave -> master)
//   OVF            signed overflow of the last computation (slave -> master)
//   DONE           one-cycle result-valid pulse (slave -> master)
//   STATE [1:0]    current FSM state (slave -> master)
interface calc_operand_fsm_if #(
  parameter int N = 8
);
  logic [N-1:0] SW;
  logic         OP;
  logic         KEY;
  logic [N-1:0] DISP;
  logic         OVF;
  logic         DONE;
  logic [1:0]   STATE;

  modport master (
    output SW, OP, KEY,
    input  DISP, OVF, DONE, STATE
  );

  modport slave (
    input  SW, OP, KEY,
    output DISP, OVF, DONE, STATE
  );
endinterface

// File: rtl/calc_operand_fsm.sv
// rtl/calc_operand_fsm.sv - operand entry FSM with key debounce for the 8-bit add/sub calculator
//
// Purpose: synchronizes and debounces the pushbutton, steps through operand
// A entry, operand B entry, compute and show, and drives the display value.
// Ports:
//   clk      system clock
//   reset_n  synchronous active-low reset
//   bus      calc_operand_fsm_if.slave: SW, OP, KEY in; DISP, OVF, DONE, STATE out
module calc_operand_fsm #(
  parameter int N         = 8,
  parameter int DB_CYCLES = 250000
) (
  input  logic                clk,
  input  logic                reset_n,
  calc_operand_fsm_if.slave   bus
);

  localparam int CW = $clog2(DB_CYCLES + 1);

  typedef enum logic [1:0] {
    S_A    = 2'd0,
    S_B    = 2'd1,
    S_CALC = 2'd2,
    S_SHOW = 2'd3
  } state_t;

  // Key path
  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          level_q, level_d;
  logic          level_dly_q, level_dly_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          press;

  // Datapath and control
  state_t        state_q, state_d;
  logic [N-1:0]  a_q, a_d;
  logic [N-1:0]  b_q, b_d;
  logic          op_q, op_d;
  logic [N-1:0]  r_q, r_d;
  logic [N-1:0]  disp_q, disp_d;
  logic          ovf_q, ovf_d;
  logic          done_q, done_d;
  logic [N-1:0]  result;

  // Debounce: the level only follows k_sync after DB_CYCLES consecutive
  // differing cycles; any agreeing cycle restarts the count.
  always_comb begin
    sync1_d     = bus.KEY;
    sync2_d     = sync1_q;
    level_d     = level_q;
    cnt_d       = '0;
    level_dly_d = level_q;
    if (sync2_q != level_q) begin
      if (cnt_q == CW'(DB_CYCLES - 1)) begin
        level_d = sync2_q;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Falling edge of the debounced level only; release is ignored.
  assign press = level_dly_q & ~level_q;

  assign result = op_q ? (a_q - b_q) : (a_q + b_q);

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    r_d     = r_q;
    disp_d  = disp_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;
    case (state_q)
      S_A: begin
        disp_d = bus.SW;
        if (press) begin
          a_d     = bus.SW;
          state_d = S_B;
        end
      end
      S_B: begin
        disp_d = bus.SW;
        if (press) begin
          b_d     = bus.SW;
          op_d    = bus.OP;
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        // DISP holds here; a press arriving in this cycle is dropped.
        r_d = result;
        if (op_q) begin
          ovf_d = (a_q[N-1] != b_q[N-1]) && (result[N-1] != a_q[N-1]);
        end else begin
          ovf_d = (a_q[N-1] == b_q[N-1]) && (result[N-1] != a_q[N-1]);
        end
        done_d  = 1'b1;
        state_d = S_SHOW;
      end
      S_SHOW: begin
        disp_d = r_q;
        if (press) begin
          ovf_d   = 1'b0;
          state_d = S_A;
        end
      end
      default: state_d = S_A;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      level_q     <= 1'b1;
      level_dly_q <= 1'b1;
      cnt_q       <= '0;
      state_q     <= S_A;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= 1'b0;
      r_q         <= '0;
      disp_q      <= '0;
      ovf_q       <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      level_q     <= level_d;
      level_dly_q <= level_dly_d;
      cnt_q       <= cnt_d;
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      op_q        <= op_d;
      r_q         <= r_d;
      disp_q      <= disp_d;
      ovf_q       <= ovf_d;
      done_q      <= done_d;
    end
  end

  assign bus.DISP  = disp_q;
  assign bus.OVF   = ovf_q;
  assign bus.DONE  = done_q;
  assign bus.STATE = state_q;

endmodule

// File: tb/tb_calc_operand_fsm.sv
// tb/tb_calc_operand_fsm.sv - scoreboard bench for calc_operand_fsm
module tb_calc_operand_fsm;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  calc_operand_fsm_if #(.N(8)) bus ();

  calc_operand_fsm #(.N(8), .DB_CYCLES(4)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int done_cnt = 0;
  logic [8:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: on every DONE pop the expected result, then check DISP/OVF
  // one cycle later and that DONE has dropped.
  initial begin
    logic [8:0] e;
    forever begin
      @(negedge clk);
      if (reset_n && bus.DONE) begin
        done_cnt++;
        check("state_at_done", 32'(bus.STATE), 32'd3);
        if (exp_q.size() == 0) begin
          check("unexpected_done", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          @(negedge clk);
          check("result_disp", 32'(bus.DISP), 32'(e[8:1]));
          check("result_ovf", 32'(bus.OVF), 32'(e[0]));
          check("done_one_cycle", 32'(bus.DONE), 32'd0);
        end
      end
    end
  end

  // Press with latency check (2 + DB_CYCLES + 1 = 7, +-1), then release.
  task automatic press();
    logic [1:0] prev;
    int n;
    @(negedge clk);
    prev = bus.STATE;
    bus.KEY = 1'b0;
    n = 0;
    while (n < 20 && bus.STATE == prev) begin
      @(posedge clk);
      #1;
      n++;
    end
    vectors++;
    if (n < 6 || n > 8) begin
      miscompares++;
      $display("FAIL press_latency: got %0d cycles, expected 6..8", n);
    end
    repeat (4) @(negedge clk);
    bus.KEY = 1'b1;
    repeat (12) @(negedge clk);
  endtask

  task automatic do_calc(input logic [7:0] a, input logic [7:0] b, input logic op,
                         input logic [7:0] er, input logic eo);
    int d0;
    bus.SW = a;
    press();
    bus.SW = b;
    bus.OP = op;
    d0 = done_cnt;
    exp_q.push_back({er, eo});
    press();
    check("state_show", 32'(bus.STATE), 32'd3);
    check("done_count", 32'(done_cnt - d0), 32'd1);
    bus.OP = ~op;
  endtask

  task automatic back_to_a();
    press();
    check("state_back_a", 32'(bus.STATE), 32'd0);
    check("ovf_cleared", 32'(bus.OVF), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int d0;
    int adv;
    logic [1:0] prev;

    // 1. Reset
    bus.KEY = 1'b1;
    bus.SW  = 8'h55;
    bus.OP  = 1'b0;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_state", 32'(bus.STATE), 32'd0);
    check("rst_ovf", 32'(bus.OVF), 32'd0);
    check("rst_done", 32'(bus.DONE), 32'd0);
    check("rst_disp", 32'(bus.DISP), 32'h00);
    reset_n = 1'b1;
    @(negedge clk);
    check("disp_tracks_sw", 32'(bus.DISP), 32'h55);

    // 2. 25 + 17 = 42
    do_calc(8'd25, 8'd17, 1'b0, 8'h2A, 1'b0);
    back_to_a();

    // 3. Arithmetic corners
    do_calc(8'd100, 8'd100, 1'b0, 8'hC8, 1'b1);
    back_to_a();
    do_calc(8'h80, 8'h01, 1'b1, 8'h7F, 1'b1);
    back_to_a();
    do_calc(8'd5, 8'd9, 1'b1, 8'hFC, 1'b0);
    back_to_a();
    do_calc(8'hFF, 8'h01, 1'b0, 8'h00, 1'b0);
    back_to_a();
    do_calc(8'h7F, 8'hFF, 1'b1, 8'h80, 1'b1);
    back_to_a();

    // 4. Short glitches are ignored
    d0 = done_cnt;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      bus.KEY = 1'b0;
      repeat (2) @(negedge clk);
      bus.KEY = 1'b1;
      repeat (3) @(negedge clk);
    end
    repeat (10) @(negedge clk);
    check("glitch_state", 32'(bus.STATE), 32'd0);
    check("glitch_done", 32'(done_cnt - d0), 32'd0);

    // Held key gives exactly one advance; A captured as 0x10
    bus.SW = 8'h10;
    @(negedge clk);
    prev = bus.STATE;
    adv = 0;
    bus.KEY = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.STATE != prev) adv++;
      prev = bus.STATE;
    end
    bus.KEY = 1'b1;
    repeat (12) @(negedge clk);
    check("held_advances", 32'(adv), 32'd1);
    check("held_state", 32'(bus.STATE), 32'd1);
    check("a_captured", 32'(dut.a_q), 32'h10);

    // 5. Reset mid-operation in S_B
    bus.SW = 8'h33;
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    check("mid_rst_state", 32'(bus.STATE), 32'd0);
    check("mid_rst_a", 32'(dut.a_q), 32'h00);
    check("mid_rst_disp", 32'(bus.DISP), 32'h00);
    check("mid_rst_ovf", 32'(bus.OVF), 32'd0);
    reset_n = 1'b1;
    repeat (12) @(negedge clk);
    do_calc(8'd60, 8'd70, 1'b0, 8'h82, 1'b1);

    // 6. SW/OP changes in S_SHOW have no effect
    for (int i = 0; i < 6; i++) begin
      bus.SW = 8'(i * 37 + 1);
      bus.OP = i[0];
      @(negedge clk);
      check("show_disp_hold", 32'(bus.DISP), 32'h82);
      check("show_ovf_hold", 32'(bus.OVF), 32'd1);
    end
    bus.SW = 8'hA5;
    back_to_a();
    @(negedge clk);
    check("after_show_disp", 32'(bus.DISP), 32'hA5);
    bus.SW = 8'h3C;
    @(negedge clk);
    check("after_show_track", 32'(bus.DISP), 32'h3C);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
